// File: rtl/config_readback_pkg.sv
// Shared types and width helpers for the config readback capture block.
package config_readback_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    DONE
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_REG_WIDTH    = 5164;
  localparam int unsigned DEF_BUFFER_DEPTH = 16;

  // Width of a counter able to hold 0..max_bits inclusive.
  function automatic int unsigned len_width(input int unsigned max_bits);
    return $clog2(max_bits + 1);
  endfunction

endpackage

// File: rtl/config_readback_fifo.sv
// Synchronous show-ahead FIFO.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data,
//        full, empty, count (occupancy, one bit wider than the pointers).
module config_readback_fifo
  import config_readback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_BUFFER_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A push into a full FIFO still lands when a pop frees the slot this cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Head is forced to zero when empty so the output has a defined reset value.
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/config_readback_capture.sv
// Samples ConfigOut on each rising ConfigClk, packs bits LSB-first into
// words and queues them for a valid/ready consumer.
// Ports: S_AXI_ACLK/S_AXI_ARESET (sync, active-high), ConfigClk, ConfigOut,
//        capture_start/capture_len, capture_busy, capture_done, bit_count,
//        overflow, word_data/word_valid/word_ready.
module config_readback_capture
  import config_readback_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CONFIG_REG_WIDTH   = DEF_REG_WIDTH,
  parameter int unsigned BUFFER_DEPTH       = DEF_BUFFER_DEPTH
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  input  logic                                   ConfigClk,
  input  logic                                   ConfigOut,
  input  logic                                   capture_start,
  input  logic [len_width(CONFIG_REG_WIDTH)-1:0] capture_len,
  output logic                                   capture_busy,
  output logic                                   capture_done,
  output logic [len_width(CONFIG_REG_WIDTH)-1:0] bit_count,
  output logic                                   overflow,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          word_data,
  output logic                                   word_valid,
  input  logic                                   word_ready
);

  localparam int unsigned LW = len_width(CONFIG_REG_WIDTH);
  localparam int unsigned IW = $clog2(C_S_AXI_DATA_WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(C_S_AXI_DATA_WIDTH - 1);

  state_t                         state;
  logic                           cout_m;
  logic                           cout_s;
  logic                           cclk_q;
  logic                           rise;
  logic [LW-1:0]                  len_q;
  logic [IW-1:0]                  idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]  pack;
  logic [C_S_AXI_DATA_WIDTH-1:0]  pack_next;
  logic [LW-1:0]                  count_next;
  logic                           last_bit;
  logic                           word_end;
  logic                           push_req;
  logic [C_S_AXI_DATA_WIDTH-1:0]  push_word;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [$clog2(BUFFER_DEPTH):0]  fifo_count;
  logic                           drop;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      cout_m <= 1'b0;
      cout_s <= 1'b0;
      cclk_q <= 1'b0;
    end else begin
      cout_m <= ConfigOut;
      cout_s <= cout_m;
      cclk_q <= ConfigClk;
    end
  end

  assign rise = ConfigClk & ~cclk_q;

  always_comb begin
    pack_next      = pack;
    pack_next[idx] = cout_s;
  end

  assign count_next = bit_count + LW'(1);
  assign last_bit   = (count_next == len_q);
  assign word_end   = (idx == IDX_LAST) || last_bit;

  assign word_valid = ~fifo_empty;
  assign drop       = push_req & fifo_full & ~(word_valid & word_ready);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state        <= IDLE;
      len_q        <= '0;
      bit_count    <= '0;
      idx          <= '0;
      pack         <= '0;
      push_req     <= 1'b0;
      push_word    <= '0;
      capture_busy <= 1'b0;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      push_req     <= 1'b0;
      capture_done <= 1'b0;
      if (drop) overflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (capture_start) begin
            if (capture_len != '0) begin
              len_q        <= capture_len;
              bit_count    <= '0;
              idx          <= '0;
              pack         <= '0;
              overflow     <= 1'b0;
              capture_busy <= 1'b1;
              state        <= SHIFT;
            end else begin
              capture_done <= 1'b1;
              state        <= DONE;
            end
          end
        end

        SHIFT: begin
          if (rise) begin
            bit_count <= count_next;
            // Completed words are staged in push_word so the pack register
            // can start the next word immediately.
            if (word_end) begin
              push_req  <= 1'b1;
              push_word <= pack_next;
              pack      <= '0;
              idx       <= '0;
            end else begin
              pack <= pack_next;
              idx  <= idx + IW'(1);
            end
            if (last_bit) state <= FLUSH;
          end
        end

        FLUSH: begin
          capture_busy <= 1'b0;
          capture_done <= 1'b1;
          state        <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  config_readback_fifo #(
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .DEPTH      (BUFFER_DEPTH)
  ) u_fifo (
    .clk       (S_AXI_ACLK),
    .rst       (S_AXI_ARESET),
    .push      (push_req),
    .push_data (push_word),
    .pop       (word_ready),
    .pop_data  (word_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  fifo_count_consistent: assert property (
    @(posedge S_AXI_ACLK) disable iff (S_AXI_ARESET)
      (fifo_count == '0) == fifo_empty
  );

endmodule

// File: tb/tb_config_readback_capture.sv
module tb_config_readback_capture;

  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 5164;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(RW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          config_clk;
  logic          config_out;
  logic          capture_start;
  logic [LW-1:0] capture_len;
  logic          capture_busy;
  logic          capture_done;
  logic [LW-1:0] bit_count;
  logic          overflow;
  logic [DW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   n_done   = 0;
  int unsigned   n_pops   = 0;
  bit            busy_seen = 1'b0;
  logic [DW-1:0] sb [$];
  logic [255:0]  bits_v;

  always #5 clk = ~clk;

  config_readback_capture #(
    .C_S_AXI_DATA_WIDTH (DW),
    .CONFIG_REG_WIDTH   (RW),
    .BUFFER_DEPTH       (DEPTH)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .ConfigClk     (config_clk),
    .ConfigOut     (config_out),
    .capture_start (capture_start),
    .capture_len   (capture_len),
    .capture_busy  (capture_busy),
    .capture_done  (capture_done),
    .bit_count     (bit_count),
    .overflow      (overflow),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: a pop happens at the next posedge when valid & ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (capture_done) n_done++;
      if (capture_busy) busy_seen = 1'b1;
      if (word_valid && word_ready) begin
        n_pops++;
        if (sb.size() == 0) check_eq("spurious_word", {31'b0, word_valid}, 32'h0);
        else                check_eq("word", word_data, sb.pop_front());
      end
    end
  end

  function automatic logic [31:0] exp_word(input int unsigned w, input int unsigned len);
    logic [31:0] r = '0;
    for (int unsigned b = 0; b < 32; b++)
      if (w * 32 + b < len) r[b] = bits_v[w * 32 + b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int unsigned len);
    capture_len   = LW'(len);
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
  endtask

  task automatic randomize_bits();
    for (int i = 0; i < 8; i++) bits_v[i * 32 +: 32] = $urandom();
  endtask

  // Each bit: data set up, ConfigClk low 4 cycles, high 4 cycles.
  task automatic shift_bits(input int unsigned first, input int unsigned n, input bit chk_last);
    for (int unsigned i = 0; i < n; i++) begin
      config_out = bits_v[first + i];
      config_clk = 1'b0;
      repeat (4) tick();
      config_clk = 1'b1;
      tick();
      if (chk_last && i == n - 1) check_eq("done_early", {31'b0, capture_done}, 32'h0);
      tick();
      if (chk_last && i == n - 1) begin
        check_eq("done_latency", {31'b0, capture_done}, 32'h1);
        check_eq("valid_latency", {31'b0, word_valid}, 32'h1);
      end
      tick();
      tick();
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_busy",     {31'b0, capture_busy}, 32'h0);
    check_eq("rst_done",     {31'b0, capture_done}, 32'h0);
    check_eq("rst_bitcount", 32'(bit_count), 32'h0);
    check_eq("rst_overflow", {31'b0, overflow}, 32'h0);
    check_eq("rst_valid",    {31'b0, word_valid}, 32'h0);
    check_eq("rst_data",     word_data, 32'h0);
  endtask

  task automatic drain();
    word_ready = 1'b1;
    for (int i = 0; i < 40 && word_valid; i++) tick();
    word_ready = 1'b0;
    check_eq("drain_empty", {31'b0, word_valid}, 32'h0);
    check_eq("sb_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    int unsigned p0;

    rst           = 1'b1;
    config_clk    = 1'b0;
    config_out    = 1'b0;
    capture_start = 1'b0;
    capture_len   = '0;
    word_ready    = 1'b0;
    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;
    tick();

    // 8 bits 1,0,1,1,0,0,1,0 -> 0x4D
    bits_v = '0;
    bits_v[7:0] = 8'b0100_1101;
    sb.push_back(32'h0000_004D);
    d0 = n_done;
    start(8);
    check_eq("busy_shift", {31'b0, capture_busy}, 32'h1);
    shift_bits(0, 8, 1'b1);
    check_eq("len8_bitcount", 32'(bit_count), 32'd8);
    check_eq("len8_done_cnt", n_done - d0, 32'd1);
    check_eq("len8_busy_end", {31'b0, capture_busy}, 32'h0);
    drain();

    // 64 alternating bits starting with 1, consumer always ready
    bits_v = {128{2'b01}};
    sb.push_back(32'h5555_5555);
    sb.push_back(32'h5555_5555);
    word_ready = 1'b1;
    d0 = n_done;
    start(64);
    shift_bits(0, 64, 1'b0);
    repeat (3) tick();
    word_ready = 1'b0;
    check_eq("len64_overflow", {31'b0, overflow}, 32'h0);
    check_eq("len64_sb_empty", 32'(sb.size()), 32'h0);
    check_eq("len64_bitcount", 32'(bit_count), 32'd64);
    check_eq("len64_done_cnt", n_done - d0, 32'd1);

    // Zero-length capture
    d0 = n_done;
    busy_seen = 1'b0;
    start(0);
    check_eq("len0_done", {31'b0, capture_done}, 32'h1);
    check_eq("len0_busy", {31'b0, capture_busy}, 32'h0);
    tick();
    check_eq("len0_done_pulse", {31'b0, capture_done}, 32'h0);
    repeat (3) tick();
    check_eq("len0_busy_seen", {31'b0, busy_seen}, 32'h0);
    check_eq("len0_valid", {31'b0, word_valid}, 32'h0);
    check_eq("len0_done_cnt", n_done - d0, 32'd1);

    // 160 bits into a depth-4 FIFO with no consumer: 5th word dropped
    randomize_bits();
    for (int unsigned w = 0; w < 4; w++) sb.push_back(exp_word(w, 160));
    d0 = n_done;
    p0 = n_pops;
    start(160);
    shift_bits(0, 160, 1'b0);
    check_eq("ovf_flag", {31'b0, overflow}, 32'h1);
    check_eq("ovf_bitcount", 32'(bit_count), 32'd160);
    check_eq("ovf_done_cnt", n_done - d0, 32'd1);
    drain();
    check_eq("ovf_pops", n_pops - p0, 32'd4);

    // Reset after 40 bits of a 100-bit capture
    randomize_bits();
    start(100);
    shift_bits(0, 40, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_values();
    tick();
    rst = 1'b0;
    tick();
    randomize_bits();
    sb.push_back(exp_word(0, 32));
    word_ready = 1'b1;
    d0 = n_done;
    p0 = n_pops;
    start(32);
    shift_bits(0, 32, 1'b0);
    repeat (3) tick();
    word_ready = 1'b0;
    check_eq("post_rst_pops", n_pops - p0, 32'd1);
    check_eq("post_rst_sb_empty", 32'(sb.size()), 32'h0);
    check_eq("post_rst_bitcount", 32'(bit_count), 32'd32);
    check_eq("post_rst_done_cnt", n_done - d0, 32'd1);

    // Second start mid-capture with a different length is ignored
    randomize_bits();
    sb.push_back(exp_word(0, 40));
    sb.push_back(exp_word(1, 40));
    word_ready = 1'b1;
    d0 = n_done;
    p0 = n_pops;
    start(40);
    shift_bits(0, 10, 1'b0);
    start(8);
    check_eq("restart_busy", {31'b0, capture_busy}, 32'h1);
    shift_bits(10, 30, 1'b0);
    repeat (3) tick();
    word_ready = 1'b0;
    check_eq("restart_bitcount", 32'(bit_count), 32'd40);
    check_eq("restart_pops", n_pops - p0, 32'd2);
    check_eq("restart_sb_empty", 32'(sb.size()), 32'h0);
    check_eq("restart_done_cnt", n_done - d0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
